mem_arbiter: RTL and testbench

Two-requester controller for the 32 x 8 single-port `memRAM`. After reset it zero-fills the whole RAM. It then shares the single RAM port between requesters 0 and 1 with round-robin arbitration and valid/ready request handshakes. Read responses return on fixed-latency response channels. It sits between the datapath clients and `memRAM`, which is instantiated one level up and wired to the `ram_*` ports.

---
 rtl/mem_arbiter_pkg.sv | 17 +
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arbiter_arb.sv | 37 +++
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the two-requester RAM controller.
package mem_arb_pkg;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 5;
  localparam int RAM_DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Requester ids, carried as the response tag.
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response channels of both requesters plus the init flag.
interface mem_arbiter_if #(
  parameter int DATA_W = mem_arb_pkg::DATA_W,
  parameter int ADDR_W = mem_arb_pkg::ADDR_W
);

  logic              req0_valid;
  logic              req0_ready;
  logic              req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req1_valid;
  logic              req1_ready;
  logic              req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_rdata;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_rdata;
  logic              init_done;

  // Requester side.
  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    input  init_done
  );

  // Controller side.
  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    output init_done
  );

endinterface

// File: rtl/mem_arbiter_arb.sv
// Two-way round-robin arbiter: combinational one-hot grant, registered
// priority pointer that moves to the loser after every grant.
module rr_arbiter2 (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);
  import mem_arb_pkg::*;

  logic ptr;  // id of the requester that wins a tie

  // Grant selection from the valids and the priority pointer.
  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (valid == 2'b11) begin
        grant = (ptr == REQ1) ? 2'b10 : 2'b01;
      end else begin
        grant = valid;
      end
    end
  end

  // Pointer update: the requester not granted gets priority next.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ptr <= REQ0;
    end else if (grant[0]) begin
      ptr <= REQ1;
    end else if (grant[1]) begin
      ptr <= REQ0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester controller for a single-port synchronous RAM. Zero-fills
// the RAM after reset, then arbitrates round-robin and returns read data
// two cycles after acceptance on the requester's response channel.
module mem_arbiter #(
  parameter int DATA_W = mem_arb_pkg::DATA_W,
  parameter int ADDR_W = mem_arb_pkg::ADDR_W
) (
  input  logic              Clock,
  input  logic              Reset,
  mem_arbiter_if.slave      bus,
  output logic [DATA_W-1:0] ram_D,
  output logic [ADDR_W-1:0] ram_Address,
  output logic              ram_WE,
  input  logic [DATA_W-1:0] ram_Q
);
  import mem_arb_pkg::*;

  state_t            state;
  logic [ADDR_W:0]   clr_cnt;   // extra bit flags completion after the last address
  logic              init_done_q;
  logic              run;
  logic [1:0]        grant;

  logic              acc_p0;
  logic              we_p0;
  logic              tag_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;

  logic              vld_p1;    // read command on the RAM port this cycle
  logic              tag_p1;

  logic              vld_p2;    // ram_Q holds that read's data this cycle
  logic              tag_p2;

  assign run = (state == ST_RUN);

  rr_arbiter2 u_arb (
    .Clock (Clock),
    .Reset (Reset),
    .en    (run),
    .valid ({bus.req1_valid, bus.req0_valid}),
    .grant (grant)
  );

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign bus.init_done  = init_done_q;

  // ---- p0: acceptance; select the granted requester's command ----
  always_comb begin
    acc_p0   = grant[0] | grant[1];
    tag_p0   = grant[1] ? REQ1 : REQ0;
    we_p0    = grant[1] ? bus.req1_we    : bus.req0_we;
    addr_p0  = grant[1] ? bus.req1_addr  : bus.req0_addr;
    wdata_p0 = grant[1] ? bus.req1_wdata : bus.req0_wdata;
  end

  // ---- p1: RAM drive; clear FSM and accepted-command registers ----
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= ST_CLEAR;
      clr_cnt     <= '0;
      init_done_q <= 1'b0;
      ram_WE      <= 1'b0;
      ram_Address <= '0;
      ram_D       <= '0;
      vld_p1      <= 1'b0;
      tag_p1      <= REQ0;
    end else begin
      case (state)
        ST_CLEAR: begin
          vld_p1 <= 1'b0;
          if (clr_cnt[ADDR_W]) begin
            state       <= ST_RUN;
            init_done_q <= 1'b1;
            ram_WE      <= 1'b0;
          end else begin
            ram_WE      <= 1'b1;
            ram_Address <= clr_cnt[ADDR_W-1:0];
            ram_D       <= '0;
            clr_cnt     <= clr_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          // Idle cycles keep address/data and only drop WE.
          ram_WE <= acc_p0 & we_p0;
          vld_p1 <= acc_p0 & ~we_p0;
          tag_p1 <= tag_p0;
          if (acc_p0) begin
            ram_Address <= addr_p0;
            ram_D       <= wdata_p0;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  // ---- p2: RAM output valid; response tag follows the read ----
  always_ff @(posedge Clock) begin
    if (Reset) begin
      vld_p2 <= 1'b0;
      tag_p2 <= REQ0;
    end else begin
      vld_p2 <= vld_p1;
      tag_p2 <= tag_p1;
    end
  end

  // Response demux: data is taken straight from ram_Q, zero when idle.
  always_comb begin
    bus.rsp0_valid = vld_p2 & (tag_p2 == REQ0);
    bus.rsp1_valid = vld_p2 & (tag_p2 == REQ1);
    bus.rsp0_rdata = bus.rsp0_valid ? ram_Q : '0;
    bus.rsp1_rdata = bus.rsp1_valid ? ram_Q : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural RAM, reference arbiter/memory model,
// and per-requester response scoreboards checked every cycle.
module tb_mem_arbiter;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [7:0] ram_D;
  logic [4:0] ram_Address;
  logic       ram_WE;
  logic [7:0] ram_Q;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .bus         (bus),
    .ram_D       (ram_D),
    .ram_Address (ram_Address),
    .ram_WE      (ram_WE),
    .ram_Q       (ram_Q)
  );

  always #5 Clock = ~Clock;

  // Synchronous single-port RAM, read data one cycle after the address.
  logic [7:0] ram [32];
  always @(posedge Clock) begin
    if (ram_WE) ram[ram_Address] <= ram_D;
    ram_Q <= ram[ram_Address];
  end

  int errs = 0;
  int nchk = 0;
  int cyc  = -1;   // cycle k = period after the k-th edge with Reset low
  bit armed = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge Clock) cyc <= Reset ? -1 : cyc + 1;

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] mmem [32];
  logic       mptr = 1'b0;

  task automatic model_accept(input int id, input logic we, input logic [4:0] a,
                              input logic [7:0] wd);
    exp_t e;
    if (we) begin
      mmem[a] = wd;
    end else begin
      e.d = mmem[a];
      e.c = cyc + 2;
      if (id == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  // Reference model and checks, sampled mid-cycle.
  always @(negedge Clock) begin
    logic [1:0] vl;
    logic [1:0] eg;
    bit         ev;
    if (armed) begin
      if (cyc == -1) begin
        q0.delete();
        q1.delete();
        mptr = 1'b0;
        foreach (mmem[i]) mmem[i] = 8'h00;
        chk("rst_ram", {ram_WE, ram_Address, ram_D}, 0);
        chk("rst_init", bus.init_done, 0);
        chk("rst_rdata", {bus.rsp1_rdata, bus.rsp0_rdata}, 0);
      end
      if (cyc >= 0 && cyc <= 31)
        chk("clear", {ram_WE, ram_Address, ram_D}, {1'b1, cyc[4:0], 8'h00});
      if (cyc == 32) chk("clear_end_we", ram_WE, 0);
      if (cyc >= 0) chk("init_done", bus.init_done, (cyc >= 32));

      vl = {bus.req1_valid, bus.req0_valid};
      eg = 2'b00;
      if (cyc >= 32) eg = (vl == 2'b11) ? (mptr ? 2'b10 : 2'b01) : vl;
      chk("grant", {bus.req1_ready, bus.req0_ready}, eg);
      if (eg[0]) begin
        model_accept(0, bus.req0_we, bus.req0_addr, bus.req0_wdata);
        mptr = 1'b1;
      end else if (eg[1]) begin
        model_accept(1, bus.req1_we, bus.req1_addr, bus.req1_wdata);
        mptr = 1'b0;
      end

      ev = (q0.size() > 0) && (q0[0].c == cyc);
      chk("rsp0_valid", bus.rsp0_valid, ev);
      if (ev) chk("rsp0_rdata", bus.rsp0_rdata, q0[0].d);
      if (q0.size() > 0 && q0[0].c <= cyc) void'(q0.pop_front());

      ev = (q1.size() > 0) && (q1[0].c == cyc);
      chk("rsp1_valid", bus.rsp1_valid, ev);
      if (ev) chk("rsp1_rdata", bus.rsp1_rdata, q1[0].d);
      if (q1.size() > 0 && q1[0].c <= cyc) void'(q1.pop_front());
    end
  end

  task automatic drv(input int id, input logic v, input logic we, input logic [4:0] a,
                     input logic [7:0] d);
    if (id == 0) begin
      bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d;
    end else begin
      bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d;
    end
  endtask

  function automatic logic rdy(input int id);
    return (id == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  // Present one command, hold it until accepted, then drop valid.
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input int id, input logic we, input logic [4:0] a, input logic [7:0] d);
    int n = 0;
    drv(id, 1'b1, we, a, d);
    #1;
    while (!rdy(id) && n < 200) begin
      @(posedge Clock); #2;
      n++;
    end
    if (n >= 200) chk("accept_timeout", rdy(id), 1);
    @(posedge Clock); #1;
    drv(id, 1'b0, 1'b0, 5'd0, 8'h00);
  endtask

  task automatic wait_init();
    int n = 0;
    while (cyc < 34 && n < 200) begin
      @(posedge Clock); #1;
      n++;
    end
    if (n >= 200) chk("init_timeout", bus.init_done, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    Reset = 1'b1;
    drv(0, 1'b0, 1'b0, 5'd0, 8'h00);
    drv(1, 1'b0, 1'b0, 5'd0, 8'h00);
    @(posedge Clock); #1;
    armed = 1'b1;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;

    // Clear with no requests, then read a cleared location.
    wait_init();
    issue(0, 1'b0, 5'd5, 8'h00);
    repeat (3) @(posedge Clock);
    #1;

    // Single writer then reader, back to back.
    issue(0, 1'b1, 5'd3, 8'hA5);
    issue(0, 1'b0, 5'd3, 8'h00);
    repeat (3) @(posedge Clock);
    #1;

    // Both requesters valid every cycle.
    fork
      begin
        for (int i = 0; i < 8; i += 2) issue(0, 1'b1, 5'(i), 8'(8'h10 + i));
      end
      begin
        for (int j = 1; j < 8; j += 2) issue(1, 1'b1, 5'(j), 8'(8'h10 + j));
      end
    join
    for (int k = 0; k < 8; k++) issue(1, 1'b0, 5'(k), 8'h00);
    repeat (3) @(posedge Clock);
    #1;

    // Cross-requester read-after-write on the top address.
    issue(0, 1'b1, 5'd31, 8'hFF);
    issue(1, 1'b0, 5'd31, 8'h00);
    repeat (3) @(posedge Clock);
    #1;

    // Requests held valid across a fresh clear.
    Reset = 1'b1;
    drv(0, 1'b1, 1'b0, 5'd3, 8'h00);
    drv(1, 1'b1, 1'b0, 5'd31, 8'h00);
    @(posedge Clock); #1;
    Reset = 1'b0;
    n = 0;
    while (!bus.req0_ready && !bus.req1_ready && n < 200) begin
      @(posedge Clock); #1;
      n++;
    end
    chk("first_grant", {bus.req1_ready, bus.req0_ready}, 2'b01);
    @(posedge Clock); #1;
    drv(0, 1'b0, 1'b0, 5'd0, 8'h00);
    issue(1, 1'b0, 5'd31, 8'h00);
    repeat (3) @(posedge Clock);
    #1;

    // Reset the cycle after a read is accepted: response is dropped.
    issue(0, 1'b0, 5'd3, 8'h00);
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    wait_init();
    issue(1, 1'b0, 5'd7, 8'h00);
    repeat (4) @(posedge Clock);
    #1;

    chk("scoreboard_drain", q0.size() + q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
